// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT -> RUN -> HALT fetch-address FSM with prioritised redirects.
// Define PC_SEQ_EXCEPTION_EN to add the exc input, epc output and the EXC_VEC redirect.
module pc_sequencer #(
    parameter int             n         = 32,
    parameter logic [n-1:0]   RESET_VEC = 32'h0000_0000,
    parameter logic [n-1:0]   EXC_VEC   = 32'h0000_0080
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [n-1:0] branch_target,
    input  logic         jump,
    input  logic [n-1:0] jump_target,
    input  logic         halt,
    input  logic         resume,
    input  logic         imem_ready,
`ifdef PC_SEQ_EXCEPTION_EN
    input  logic         exc,
`endif
    output logic [n-1:0] pc,
    output logic         imem_req,
    output logic [1:0]   state
`ifdef PC_SEQ_EXCEPTION_EN
    ,
    output logic [n-1:0] epc
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic         exc_req;
    logic         epc_capture;
    logic         fetch_accept;

    // Without the exception option the request is tied low so every exc term folds away.
`ifdef PC_SEQ_EXCEPTION_EN
    assign exc_req = exc;
`else
    assign exc_req = 1'b0;
`endif

    assign imem_req     = (state_q == RUN);
    assign fetch_accept = imem_req && imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_capture = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_d    = RESET_VEC;
            end
            RUN: begin
                if (exc_req) begin
                    pc_d        = EXC_VEC;
                    epc_capture = 1'b1;
                end else if (jump) begin
                    pc_d = jump_target;
                end else if (branch_taken) begin
                    pc_d = branch_target;
                end else if (!stall && fetch_accept) begin
                    pc_d = pc_q + n'(4);
                end
                if (halt) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // Only an exception can redirect a halted sequencer; it also wakes it.
                if (exc_req) begin
                    pc_d        = EXC_VEC;
                    epc_capture = 1'b1;
                    state_d     = RUN;
                end else if (!halt && resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_SEQ_EXCEPTION_EN
    logic [n-1:0] epc_q, epc_d;

    assign epc_d = epc_capture ? pc_q : epc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`else
    logic unused_capture;
    assign unused_capture = epc_capture;
`endif

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  n  32  address width
  RESET_VEC  32'h0000_0000  PC value loaded at reset
  EXC_VEC  32'h0000_0080  exception redirect target
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous active-low reset
  stall  in  1  hold PC (hazard)
  branch_taken  in  1  branch redirect request
  branch_target  in  n  branch destination
  jump  in  1  jump redirect request
  jump_target  in  n  jump destination
  halt  in  1  enter HALT
  resume  in  1  leave HALT
  imem_ready  in  1  instruction memory accepts fetch
  exc  in  1  exception request (macro-gated, REQ-018)
  pc  out  n  current fetch address (registered)
  imem_req  out  1  fetch request valid
  state  out  2  BOOT=00, RUN=01, HALT=10
  epc  out  n  PC captured on exception (macro-gated)
REQ-003 Clock and reset SHALL be one clock domain, clk, with rst_n synchronous and active-low.

Function
REQ-004 States SHALL be BOOT, RUN, HALT; 2'b11 unreachable, recovers to BOOT next cycle.
REQ-005 BOOT: imem_req=0, pc held at RESET_VEC; unconditional transition to RUN after exactly one cycle.
REQ-006 RUN: imem_req=1 combinationally from state; fetch accepted when imem_req && imem_ready.
REQ-007 RUN next-PC priority, highest first: exc (if enabled) -> EXC_VEC; jump -> jump_target; branch_taken -> branch_target; stall -> hold; accepted fetch -> pc+4; else hold.
REQ-008 Redirects (exc/jump/branch) SHALL apply in the cycle presented regardless of imem_ready or stall; outstanding unaccepted fetch is abandoned.
REQ-009 pc+4 SHALL wrap modulo 2^n (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-010 Targets SHALL be loaded verbatim; bits [1:0] not masked.
REQ-011 halt in RUN: -> HALT next cycle; pc updated per REQ-007 in that same cycle (redirect wins over hold); halt outranks resume.
REQ-012 HALT: imem_req=0, pc held, all redirects ignored except exc (if enabled): exc loads EXC_VEC and returns to RUN.
REQ-013 resume in HALT (halt low) -> RUN next cycle, pc unchanged.
REQ-014 Latency: any update visible on pc one clock after the qualifying edge's inputs; no combinational input-to-pc path.

Reset
REQ-015 rst_n=0 sampled at a rising edge SHALL force state=BOOT, pc=RESET_VEC, epc=0, imem_req=0, overriding all other inputs.
REQ-016 Reset mid-fetch or mid-HALT SHALL discard state; sequence restarts at BOOT.
REQ-017 rst_n is not in any sensitivity list other than via clk.

Configuration
REQ-018 Macro PC_SEQ_EXCEPTION_EN: defined -> exc port, epc port, EXC_VEC redirect active; epc <= pc on exc acceptance (RUN or HALT).
REQ-019 Undefined -> exc and epc ports absent, no epc register, REQ-007/REQ-012 exception terms removed; remaining behaviour identical.

Verification
REQ-020 Reset then release, imem_ready=1 -> cycle1 state=BOOT pc=0 imem_req=0; cycle2 RUN pc=0; then pc 4, 8, 12.
REQ-021 RUN pc=0x10, imem_ready=0 three cycles then 1 -> pc holds 0x10 three cycles, then 0x14.
REQ-022 pc=0x20, jump=1 jump_target=0x100, branch_taken=1 branch_target=0x200, stall=1 same cycle -> pc=0x100.
REQ-023 pc=0xFFFF_FFFC, fetch accepted -> pc=0x0000_0000.
REQ-024 halt=1 at pc=0x40 -> HALT, imem_req=0, pc=0x40; branch_taken ignored; resume=1 -> RUN, pc=0x40 then 0x44.
REQ-025 With PC_SEQ_EXCEPTION_EN, pc=0x58 exc=1 -> pc=0x80, epc=0x58; rst_n=0 next cycle -> pc=0, epc=0, BOOT.
